pixel_shifter: RTL
==================

Name: pixel_shifter

Overview:
- Downstream of the line-buffer fetch stage; consumes its `load` strobe and the fetched 16-bit line-buffer word.
- Serialises the word MSB-first into 1bpp or 2bpp pixel indices.
- Maps each index through a 4-entry programmable palette and drives registered RGB to the video DAC/encoder.
- Blanks output outside active scanlines.

Parameters:
- PAL_W, 12, width of one palette entry / RGB output (4:4:4).

Ports:
- dotclk_i  in  1  dot clock; all state on rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- scanline_en_i  in  1  1 while refreshing a scanline (same signal the fetch stage sees).
- shift1_i  in  1  1bpp mode.
- shift2_i  in  1  2bpp mode; wins if both mode bits are set.
- load_i  in  1  reload strobe from fetch stage.
- lb_dat_i  in  16  line-buffer word at current fetch address; valid whenever load_i=1.
- pal_we_i  in  1  palette write enable.
- pal_adr_i  in  2  palette entry to write.
- pal_dat_i  in  PAL_W  palette write data.
- pix_idx_o  out  2  current pixel index (combinational from shift register, for debug/sprite merge).
- rgb_o  out  PAL_W  registered colour output.
- active_o  out  1  registered; 1 when rgb_o carries an active pixel.

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - Shift register = 0; rgb_o = 0; active_o = 0.
  - Palette = {0:000, 1:FFF, 2:F00, 3:00F} (zero-extended/truncated to PAL_W from the top).
  - Reset may assert at any point mid-line; on release the block resumes at the next load_i.
- Shift register sr[15:0], on each dotclk_i edge, priority order:
  1. load_i=1: sr <= lb_dat_i.
  2. Else 2bpp: sr <= {sr[13:0], 2'b00}.
  3. Else 1bpp: sr <= {sr[14:0], 1'b0}.
  4. Else (no mode): sr holds.
- Pixel index (combinational):
  - 2bpp: sr[15:14].
  - 1bpp: {1'b0, sr[15]}.
  - No mode: 2'b00.
- Word cadence: the fetch stage pulses load every 16 dots in 1bpp and every 8 dots in 2bpp. The shifter does no counting of its own; if load arrives early, the remaining bits are discarded.
- Output stage, each edge:
  - active_o <= scanline_en_i.
  - rgb_o <= scanline_en_i ? palette[pix_idx] : 0.
- Latency: a word loaded at edge E0 shows its first pixel at rgb_o after edge E1. Subsequent pixels follow one per dot with no gaps.
- Palette write: on an edge with pal_we_i=1, palette[pal_adr_i] <= pal_dat_i. A simultaneous lookup of the same entry uses the old value; the new value is visible from the next edge.
- Mode bits may change mid-line. The new shift amount applies from the next edge; sr contents are not cleared.
- While scanline_en_i=0 the fetch stage holds load high, so sr keeps reloading and rgb_o stays 0.

Test Plan:
- Reset release, no palette writes, scanline_en=1, 1bpp, load word 0xA5F0 then load low for 15 dots:
  - rgb_o from E1 = FFF,000,FFF,000, 000,FFF,000,FFF, FFF,FFF,FFF,FFF, 000,000,000,000.
  - active_o=1 throughout.
- 2bpp, load 0xE4E4, load low 7 dots:
  - indices 3,2,1,0,3,2,1,0.
  - rgb_o = 00F,F00,FFF,000 repeated.
- Palette write adr=2 dat=0x0F0 on the same edge that index 2 is looked up:
  - that pixel outputs F00.
  - the next index-2 pixel outputs 0F0.
- scanline_en=0 with load held high and lb_dat_i=0xFFFF:
  - rgb_o=000 and active_o=0.
  - First active dot after scanline_en rises shows FFF one edge later.
- Assert reset_ni low mid-word in 2bpp between edges:
  - rgb_o=000, active_o=0, and the palette returns to defaults immediately (before the next edge).
  - After release, output is 000 until the next load.
- shift1=shift2=1 with word 0x4000 → indices 1,0,... (2bpp precedence). Both mode bits 0 → index 0 constantly; sr held.

Source files
------------

// File: rtl/pixel_shifter.sv
// Serialises line-buffer words into 1bpp/2bpp palette indices and drives
// registered, blanked RGB towards the video DAC/encoder.
module pixel_shifter #(
    parameter int PAL_W = 12
) (
    input  logic             dotclk_i,
    input  logic             reset_ni,
    input  logic             scanline_en_i,
    input  logic             shift1_i,
    input  logic             shift2_i,
    input  logic             load_i,
    input  logic [15:0]      lb_dat_i,
    input  logic             pal_we_i,
    input  logic [1:0]       pal_adr_i,
    input  logic [PAL_W-1:0] pal_dat_i,
    output logic [1:0]       pix_idx_o,
    output logic [PAL_W-1:0] rgb_o,
    output logic             active_o
);

    // Defaults are 4:4:4 constants aligned to the top of the entry.
    function automatic logic [PAL_W-1:0] pal_default(input logic [11:0] v);
        logic [PAL_W+11:0] ext;
        ext = {v, {PAL_W{1'b0}}};
        return ext[PAL_W+11 -: PAL_W];
    endfunction

    logic [15:0]      sr_q;
    logic [PAL_W-1:0] pal_q [4];
    logic [1:0]       pix_idx;

    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pal_q[0] <= pal_default(12'h000);
            pal_q[1] <= pal_default(12'hFFF);
            pal_q[2] <= pal_default(12'hF00);
            pal_q[3] <= pal_default(12'h00F);
        end else if (pal_we_i) begin
            pal_q[pal_adr_i] <= pal_dat_i;
        end
    end

    // No internal bit counter: an early load simply discards leftover bits.
    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= lb_dat_i;
        end else if (shift2_i) begin
            sr_q <= {sr_q[13:0], 2'b00};
        end else if (shift1_i) begin
            sr_q <= {sr_q[14:0], 1'b0};
        end
    end

    always_comb begin
        pix_idx = 2'b00;
        if (shift2_i) begin
            pix_idx = sr_q[15:14];
        end else if (shift1_i) begin
            pix_idx = {1'b0, sr_q[15]};
        end
    end

    assign pix_idx_o = pix_idx;

    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rgb_o    <= '0;
            active_o <= 1'b0;
        end else begin
            active_o <= scanline_en_i;
            rgb_o    <= scanline_en_i ? pal_q[pix_idx] : '0;
        end
    end

endmodule
